// File: rtl/sc_comp_if.sv
// Debug register-read port of the single-cycle MIPS computer.
interface sc_comp_if;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;

  modport master (output reg_sel, input reg_data);
  modport slave  (input reg_sel, output reg_data);
endinterface

// File: rtl/sc_comp.sv
// Single-cycle MIPS computer: CPU core, 128-word instruction ROM and 128-word data RAM.
// Every rising clock edge retires one instruction; GPRs are readable through the debug port.
module sc_im (
  input  logic [6:0]  addr,
  output logic [31:0] dout
);
  logic [31:0] ROM [0:127];

  assign dout = ROM[addr];
endmodule

module sc_dm (
  input  logic        clk,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  logic [31:0] RAM [0:127];

  always_ff @(posedge clk)
    if (we) RAM[addr] <= wd;

  assign rd = RAM[addr];
endmodule

module sc_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [6:0]  im_addr,
  input  logic [31:0] dm_rd,
  output logic        dm_we,
  output logic [6:0]  dm_addr,
  output logic [31:0] dm_wd,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;

  logic [31:0] PC;
  logic [31:0] gpr [0:31];
  logic [31:0] pc4, next_pc, rs_v, rt_v, sext, zext, alu, wd;
  logic        reg_we, is_lw, is_jal;
  logic [4:0]  wa;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  assign pc4      = PC + 32'd4;
  assign sext     = {{16{imm[15]}}, imm};
  assign zext     = {16'h0000, imm};
  // gpr[0] is only ever cleared, so it reads 0 without a special case.
  assign rs_v     = gpr[rs];
  assign rt_v     = gpr[rt];
  assign reg_data = gpr[reg_sel];
  assign im_addr  = PC[8:2];
  assign dm_addr  = alu[8:2];
  assign dm_wd    = rt_v;

  always_comb begin
    next_pc = pc4;
    alu     = '0;
    reg_we  = 1'b0;
    dm_we   = 1'b0;
    is_lw   = 1'b0;
    is_jal  = 1'b0;
    wa      = rt;
    case (op)
      OP_RTYPE: begin
        wa = rd;
        case (funct)
          6'h20, 6'h21: begin alu = rs_v + rt_v;   reg_we = 1'b1; end
          6'h22, 6'h23: begin alu = rs_v - rt_v;   reg_we = 1'b1; end
          6'h24:        begin alu = rs_v & rt_v;   reg_we = 1'b1; end
          6'h25:        begin alu = rs_v | rt_v;   reg_we = 1'b1; end
          6'h26:        begin alu = rs_v ^ rt_v;   reg_we = 1'b1; end
          6'h27:        begin alu = ~(rs_v | rt_v); reg_we = 1'b1; end
          6'h2A: begin alu = {31'd0, $signed(rs_v) < $signed(rt_v)}; reg_we = 1'b1; end
          6'h2B: begin alu = {31'd0, rs_v < rt_v};                   reg_we = 1'b1; end
          6'h00: begin alu = rt_v << shamt;                          reg_we = 1'b1; end
          6'h02: begin alu = rt_v >> shamt;                          reg_we = 1'b1; end
          6'h03: begin alu = $signed(rt_v) >>> shamt;                reg_we = 1'b1; end
          6'h08: next_pc = rs_v;
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu = rs_v + sext; reg_we = 1'b1; end
      OP_SLTI: begin alu = {31'd0, $signed(rs_v) < $signed(sext)}; reg_we = 1'b1; end
      OP_ANDI: begin alu = rs_v & zext;         reg_we = 1'b1; end
      OP_ORI:  begin alu = rs_v | zext;         reg_we = 1'b1; end
      OP_XORI: begin alu = rs_v ^ zext;         reg_we = 1'b1; end
      OP_LUI:  begin alu = {imm, 16'h0000};     reg_we = 1'b1; end
      OP_LW:   begin alu = rs_v + sext; reg_we = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin alu = rs_v + sext; dm_we = 1'b1; end
      OP_BEQ:  if (rs_v == rt_v) next_pc = pc4 + {sext[29:0], 2'b00};
      OP_BNE:  if (rs_v != rt_v) next_pc = pc4 + {sext[29:0], 2'b00};
      OP_J:    next_pc = {pc4[31:28], instr[25:0], 2'b00};
      OP_JAL: begin
        next_pc = {pc4[31:28], instr[25:0], 2'b00};
        wa      = 5'd31;
        reg_we  = 1'b1;
        is_jal  = 1'b1;
      end
      default: ;
    endcase
    wd = is_lw ? dm_rd : (is_jal ? pc4 : alu);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) PC <= '0;
    else     PC <= next_pc;

  always_ff @(posedge clk or posedge rst)
    if (rst)                          gpr <= '{default: '0};
    else if (reg_we && (wa != 5'd0))  gpr[wa] <= wd;
endmodule

module sc_comp (
  input  logic       clk,
  input  logic       rstn,
  sc_comp_if.slave   dbg
);
  logic [6:0]  im_addr, dm_addr;
  logic [31:0] instr, dm_rd, dm_wd;
  logic        dm_we;

  sc_cpu U_SCPU (
    .clk      (clk),
    .rst      (rstn),
    .instr    (instr),
    .im_addr  (im_addr),
    .dm_rd    (dm_rd),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .reg_sel  (dbg.reg_sel),
    .reg_data (dbg.reg_data)
  );

  sc_im U_IM (
    .addr (im_addr),
    .dout (instr)
  );

  sc_dm U_DM (
    .clk  (clk),
    .we   (dm_we),
    .addr (dm_addr),
    .wd   (dm_wd),
    .rd   (dm_rd)
  );
endmodule

// File: tb/tb_sc_comp.sv
// Directed bench for sc_comp: executes a fixed program and checks GPRs, PC and data RAM per step.
module tb_sc_comp;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sc_comp_if dbg ();

  sc_comp dut (
    .clk  (clk),
    .rstn (rstn),
    .dbg  (dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] exp_reg;
    logic [31:0] exp_pc;
  } step_t;

  step_t       steps [0:26];
  logic [31:0] prog  [0:127];

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input logic [4:0] sel, input logic [31:0] exp);
    dbg.reg_sel = sel;
    #1;
    check($sformatf("%s reg%0d", name, sel), dbg.reg_data, exp);
  endtask

  initial begin
    logic [31:0] exp_pc;
    dbg.reg_sel = '0;

    for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    prog[0]  = enc_i(6'h08, 0, 1, 16'd5);          // addi $1,$0,5
    prog[1]  = enc_i(6'h08, 0, 2, 16'hFFFD);       // addi $2,$0,-3
    prog[2]  = enc_r(1, 2, 3, 0, 6'h20);           // add  $3,$1,$2
    prog[3]  = enc_r(1, 2, 4, 0, 6'h22);           // sub  $4,$1,$2
    prog[4]  = enc_r(2, 1, 5, 0, 6'h2A);           // slt  $5,$2,$1
    prog[5]  = enc_r(2, 1, 6, 0, 6'h2B);           // sltu $6,$2,$1
    prog[6]  = enc_i(6'h0F, 0, 7, 16'h1234);       // lui  $7,0x1234
    prog[7]  = enc_i(6'h0D, 7, 7, 16'h5678);       // ori  $7,$7,0x5678
    prog[8]  = enc_j(6'h03, 26'h10);               // jal  0x40
    prog[9]  = enc_i(6'h09, 1, 19, 16'hFFFF);      // 0x24 addiu $19,$1,-1
    prog[10] = enc_j(6'h02, 26'h22);               // 0x28 j 0x88
    prog[16] = enc_r(0, 1, 8, 4, 6'h00);           // 0x40 sll $8,$1,4
    prog[17] = enc_i(6'h2B, 0, 7, 16'd8);          // sw   $7,8($0)
    prog[18] = enc_i(6'h23, 0, 9, 16'd8);          // lw   $9,8($0)
    prog[19] = enc_i(6'h04, 1, 1, 16'd2);          // beq  $1,$1,+2
    prog[20] = enc_i(6'h08, 0, 10, 16'd1);         // skipped
    prog[21] = enc_i(6'h08, 0, 10, 16'd2);         // skipped
    prog[22] = enc_i(6'h05, 1, 1, 16'd2);          // bne  $1,$1,+2 (falls through)
    prog[23] = enc_i(6'h08, 0, 0, 16'd7);          // addi $0,$0,7
    prog[24] = enc_i(6'h3F, 1, 10, 16'h1234);      // undefined opcode
    prog[25] = enc_r(0, 2, 11, 28, 6'h02);         // srl  $11,$2,28
    prog[26] = enc_r(0, 2, 12, 1, 6'h03);          // sra  $12,$2,1
    prog[27] = enc_i(6'h0C, 2, 13, 16'hFF00);      // andi $13,$2,0xFF00
    prog[28] = enc_r(1, 2, 14, 0, 6'h26);          // xor  $14,$1,$2
    prog[29] = enc_r(1, 0, 15, 0, 6'h27);          // nor  $15,$1,$0
    prog[30] = enc_i(6'h0A, 2, 16, 16'hFFFE);      // slti $16,$2,-2
    prog[31] = enc_i(6'h0E, 1, 17, 16'hFFFF);      // xori $17,$1,0xFFFF
    prog[32] = enc_r(1, 7, 18, 0, 6'h25);          // or   $18,$1,$7
    prog[33] = enc_r(31, 0, 0, 0, 6'h08);          // jr   $31
    prog[34] = enc_i(6'h08, 20, 20, 16'd1);        // 0x88 addi $20,$20,1
    prog[35] = enc_i(6'h04, 0, 0, 16'hFFFE);       // 0x8C beq $0,$0,-2
    for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = prog[i];

    steps[0]  = '{5'd1,  32'h00000005, 32'h04};
    steps[1]  = '{5'd2,  32'hFFFFFFFD, 32'h08};
    steps[2]  = '{5'd3,  32'h00000002, 32'h0C};
    steps[3]  = '{5'd4,  32'h00000008, 32'h10};
    steps[4]  = '{5'd5,  32'h00000001, 32'h14};
    steps[5]  = '{5'd6,  32'h00000000, 32'h18};
    steps[6]  = '{5'd7,  32'h12340000, 32'h1C};
    steps[7]  = '{5'd7,  32'h12345678, 32'h20};
    steps[8]  = '{5'd31, 32'h00000024, 32'h40};
    steps[9]  = '{5'd8,  32'h00000050, 32'h44};
    steps[10] = '{5'd7,  32'h12345678, 32'h48};
    steps[11] = '{5'd9,  32'h12345678, 32'h4C};
    steps[12] = '{5'd1,  32'h00000005, 32'h58};
    steps[13] = '{5'd1,  32'h00000005, 32'h5C};
    steps[14] = '{5'd0,  32'h00000000, 32'h60};
    steps[15] = '{5'd10, 32'h00000000, 32'h64};
    steps[16] = '{5'd11, 32'h0000000F, 32'h68};
    steps[17] = '{5'd12, 32'hFFFFFFFE, 32'h6C};
    steps[18] = '{5'd13, 32'h0000FF00, 32'h70};
    steps[19] = '{5'd14, 32'hFFFFFFF8, 32'h74};
    steps[20] = '{5'd15, 32'hFFFFFFFA, 32'h78};
    steps[21] = '{5'd16, 32'h00000001, 32'h7C};
    steps[22] = '{5'd17, 32'h0000FFFA, 32'h80};
    steps[23] = '{5'd18, 32'h1234567D, 32'h84};
    steps[24] = '{5'd31, 32'h00000024, 32'h24};
    steps[25] = '{5'd19, 32'h00000004, 32'h28};
    steps[26] = '{5'd19, 32'h00000004, 32'h88};

    // Reset held from time 0 through the first two edges.
    #2;
    check("reset_pc", dut.U_SCPU.PC, 32'h0);
    for (int s = 0; s < 32; s++) check_reg("reset", s[4:0], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;

    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("step%0d_pc", i), dut.U_SCPU.PC, steps[i].exp_pc);
      check_reg($sformatf("step%0d", i), steps[i].sel, steps[i].exp_reg);
      if (i == 10) check("dm_word2", dut.U_DM.RAM[2], 32'h12345678);
    end

    exp_pc = 32'h88;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      exp_pc = (exp_pc == 32'h88) ? 32'h8C : 32'h88;
      checks++;
      if ($isunknown(dut.U_SCPU.PC) || dut.U_SCPU.PC !== exp_pc ||
          dut.U_SCPU.instr !== prog[exp_pc[8:2]]) begin
        errors++;
        $display("FAIL loop_trace cycle %0d: pc %h instr %h expected pc %h instr %h",
                 c, dut.U_SCPU.PC, dut.U_SCPU.instr, exp_pc, prog[exp_pc[8:2]]);
      end
    end
    check_reg("loop_count", 5'd20, 32'd500);

    // Reset mid-program: PC and GPRs clear at once, data RAM keeps its word.
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("midreset_pc", dut.U_SCPU.PC, 32'h0);
    for (int s = 0; s < 32; s++) check_reg("midreset", s[4:0], 32'h0);
    check("midreset_dm", dut.U_DM.RAM[2], 32'h12345678);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rerun_pc", dut.U_SCPU.PC, 32'h04);
    check_reg("rerun", 5'd1, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
